keccak_squeeze_streamer: RTL and testbench

Output-side counterpart of the Keccak absorb path. It takes the rate portion of the permutation state and serializes it onto a 256-bit AXI-Stream-style master with byte keep. It handles fixed-length SHA3-256/512 digests and variable-length SHAKE128/256 output. When the current rate block is exhausted, it requests further permutations and bridges the gap with a 192-bit carry register.

---
 rtl/keccak_squeeze_streamer.sv | 238 +++++++++++++++++++++++
 tb/tb_keccak_squeeze_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_streamer.sv
// Keccak squeeze-side serializer: streams the rate bytes of successive permutation
// states onto a byte-keep AXI-Stream master, bridging block ends through a carry register.
module keccak_squeeze_streamer #(
    parameter int DWIDTH        = 256,
    parameter int KEEP_WIDTH    = DWIDTH / 8,
    parameter int MAX_RATE      = 1344,
    parameter int CARRY_WIDTH   = 192,
    parameter int OUT_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
    input  logic                     state_valid_i,
    input  logic [MAX_RATE-1:0]      rate_data_i,
    output logic                     state_ready_o,
    output logic                     perm_req_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        m_tdata,
    output logic [KEEP_WIDTH-1:0]    m_tkeep,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast
);

    localparam int RATE_BYTES_MAX = MAX_RATE / 8;
    localparam int CARRY_BYTES    = CARRY_WIDTH / 8;
    localparam int PTR_W          = $clog2(RATE_BYTES_MAX + 1);
    localparam int AV_W           = PTR_W + 1;
    localparam int BB_W           = $clog2(KEEP_WIDTH + 1);
    localparam int CL_W           = $clog2(CARRY_BYTES + 1);

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'd0,
        MODE_SHA3_512 = 2'd1,
        MODE_SHAKE128 = 2'd2,
        MODE_SHAKE256 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_STATE,
        ST_STREAM
    } state_e;

    function automatic logic [PTR_W-1:0] rate_of(input mode_e m);
        case (m)
            MODE_SHA3_256: return PTR_W'(136);
            MODE_SHA3_512: return PTR_W'(72);
            MODE_SHAKE128: return PTR_W'(168);
            default:       return PTR_W'(136);
        endcase
    endfunction

    state_e                   state_q;
    mode_e                    mode_q;
    logic [MAX_RATE-1:0]      buf_q;
    logic [PTR_W-1:0]         ptr_q;
    logic [CARRY_WIDTH-1:0]   carry_q;
    logic [CL_W-1:0]          carry_len_q;
    logic [OUT_LEN_WIDTH-1:0] len_rem_q;
    logic [BB_W-1:0]          cur_bytes_q;
    logic [BB_W-1:0]          cur_consumed_q;

    logic [OUT_LEN_WIDTH-1:0] start_len;
    logic                     in_wait;
    logic [MAX_RATE-1:0]      src_block;
    logic [PTR_W-1:0]         nxt_ptr;
    logic [CL_W-1:0]          nxt_clen;
    logic [OUT_LEN_WIDTH-1:0] nxt_len;
    logic [PTR_W-1:0]         rate_bytes;
    logic [PTR_W-1:0]         lo_bytes;
    logic [AV_W-1:0]          avail;
    logic [BB_W-1:0]          fm_bytes;
    logic [BB_W-1:0]          fm_consumed;
    logic                     fm_fits;
    logic                     fm_last;
    logic [KEEP_WIDTH-1:0]    fm_keep;
    logic [DWIDTH-1:0]        fm_data;
    logic [DWIDTH-1:0]        data_mask;
    logic [CARRY_WIDTH-1:0]   in_mask;
    logic [CARRY_WIDTH-1:0]   lo_mask;
    logic [CARRY_WIDTH-1:0]   lo_data;

    always_comb begin
        case (mode_e'(mode_i))
            MODE_SHA3_256: start_len = OUT_LEN_WIDTH'(32);
            MODE_SHA3_512: start_len = OUT_LEN_WIDTH'(64);
            default:       start_len = out_len_i;
        endcase
    end

    // Beat former: looks at the position the stream will be in after the current
    // beat is accepted (or at a freshly arriving state while waiting), so the
    // next beat can be registered on the same edge and keep one beat per cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        data_mask = '0;
        in_mask   = '0;
        lo_mask   = '0;

        in_wait   = (state_q == ST_WAIT_STATE);
        src_block = in_wait ? rate_data_i : buf_q;
        nxt_ptr   = in_wait ? '0 : ptr_q + PTR_W'(cur_consumed_q);
        nxt_clen  = in_wait ? carry_len_q : '0;
        nxt_len   = in_wait ? len_rem_q : len_rem_q - OUT_LEN_WIDTH'(cur_bytes_q);

        rate_bytes = rate_of(mode_q);
        if (nxt_len >= OUT_LEN_WIDTH'(KEEP_WIDTH))
            fm_bytes = BB_W'(KEEP_WIDTH);
        else
            fm_bytes = BB_W'(nxt_len);

        lo_bytes    = rate_bytes - nxt_ptr;
        avail       = AV_W'(nxt_clen) + AV_W'(lo_bytes);
        fm_fits     = (avail >= AV_W'(fm_bytes));
        fm_consumed = fm_bytes - BB_W'(nxt_clen);
        fm_last     = (OUT_LEN_WIDTH'(fm_bytes) == nxt_len);
        fm_keep     = ~({KEEP_WIDTH{1'b1}} << fm_bytes);

        for (int b = 0; b < KEEP_WIDTH; b++)
            data_mask[8*b +: 8] = {8{fm_keep[b]}};
        for (int b = 0; b < CARRY_BYTES; b++) begin
            in_mask[8*b +: 8] = {8{CL_W'(b) < nxt_clen}};
            lo_mask[8*b +: 8] = {8{PTR_W'(b) < lo_bytes}};
        end

        // Carry bytes sit at the bottom of the beat; buffer bytes follow them.
        fm_data = ((DWIDTH'(src_block >> {nxt_ptr, 3'b000}) << {nxt_clen, 3'b000})
                   | DWIDTH'(carry_q & in_mask)) & data_mask;
        lo_data = CARRY_WIDTH'(src_block >> {nxt_ptr, 3'b000}) & lo_mask;
    end

    // NOTE: the block buffer is pure data that is always overwritten before it is
    // read, so it carries no reset and stays out of the reset fan-out.
    always_ff @(posedge clk) begin
        if (state_q == ST_WAIT_STATE && state_valid_i)
            buf_q <= rate_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is only ever written with non-blocking
            // assignments so every register samples pre-edge values.
            state_q        <= ST_IDLE;
            mode_q         <= MODE_SHA3_256;
            ptr_q          <= '0;
            carry_q        <= '0;
            carry_len_q    <= '0;
            len_rem_q      <= '0;
            cur_bytes_q    <= '0;
            cur_consumed_q <= '0;
            state_ready_o  <= 1'b0;
            perm_req_o     <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            m_tdata        <= '0;
            m_tkeep        <= '0;
            m_tvalid       <= 1'b0;
            m_tlast        <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            perm_req_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q      <= mode_e'(mode_i);
                        len_rem_q   <= start_len;
                        ptr_q       <= '0;
                        carry_len_q <= '0;
                        if (start_len == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            busy_o        <= 1'b1;
                            state_ready_o <= 1'b1;
                            state_q       <= ST_WAIT_STATE;
                        end
                    end
                end

                ST_WAIT_STATE: begin
                    // Every rate exceeds a beat plus the carry, so the first beat always fits.
                    if (state_valid_i) begin
                        state_ready_o  <= 1'b0;
                        state_q        <= ST_STREAM;
                        ptr_q          <= nxt_ptr;
                        len_rem_q      <= nxt_len;
                        m_tvalid       <= 1'b1;
                        m_tdata        <= fm_data;
                        m_tkeep        <= fm_keep;
                        m_tlast        <= fm_last;
                        cur_bytes_q    <= fm_bytes;
                        cur_consumed_q <= fm_consumed;
                    end
                end

                ST_STREAM: begin
                    if (m_tvalid && m_tready) begin
                        ptr_q       <= nxt_ptr;
                        len_rem_q   <= nxt_len;
                        carry_len_q <= '0;
                        if (nxt_len == '0) begin
                            state_q  <= ST_IDLE;
                            done_o   <= 1'b1;
                            busy_o   <= 1'b0;
                            m_tvalid <= 1'b0;
                            m_tdata  <= '0;
                            m_tkeep  <= '0;
                            m_tlast  <= 1'b0;
                        end else if (fm_fits) begin
                            m_tdata        <= fm_data;
                            m_tkeep        <= fm_keep;
                            m_tlast        <= fm_last;
                            cur_bytes_q    <= fm_bytes;
                            cur_consumed_q <= fm_consumed;
                        end else begin
                            carry_q       <= lo_data;
                            carry_len_q   <= CL_W'(lo_bytes);
                            perm_req_o    <= 1'b1;
                            state_ready_o <= 1'b1;
                            state_q       <= ST_WAIT_STATE;
                            m_tvalid      <= 1'b0;
                            m_tdata       <= '0;
                            m_tkeep       <= '0;
                            m_tlast       <= 1'b0;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_streamer.sv
// Directed bench for keccak_squeeze_streamer: feeds patterned states and checks the
// byte stream, keep/last framing, permutation requests, done timing and reset abort.
module tb_keccak_squeeze_streamer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = '0;
    logic [15:0]   out_len_i = '0;
    logic          state_valid_i = 1'b0;
    logic [1343:0] rate_data_i = '0;
    logic          state_ready_o;
    logic          perm_req_o;
    logic          busy_o;
    logic          done_o;
    logic [255:0]  m_tdata;
    logic [31:0]   m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;

    keccak_squeeze_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .out_len_i    (out_len_i),
        .state_valid_i(state_valid_i),
        .rate_data_i  (rate_data_i),
        .state_ready_o(state_ready_o),
        .perm_req_o   (perm_req_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rate_of(input logic [1:0] m);
        case (m)
            2'd0:    return 136;
            2'd1:    return 72;
            2'd2:    return 168;
            default: return 136;
        endcase
    endfunction

    // Block k, byte i = (i + 37k) mod 256; bytes past the rate hold a marker that must never appear.
    function automatic logic [1343:0] make_block(input int k, input int rate);
        logic [1343:0] v;
        v = '0;
        for (int i = 0; i < 168; i++)
            v[8*i +: 8] = (i < rate) ? 8'((i + 37 * k) & 255) : 8'hA5;
        return v;
    endfunction

    function automatic logic [7:0] exp_byte(input int j, input int rate);
        return 8'(((j % rate) + 37 * (j / rate)) & 255);
    endfunction

    // ---------------- monitor (samples on the falling edge) ----------------
    int           cyc = 0;
    logic [255:0] beat_data[$];
    logic [31:0]  beat_keep[$];
    logic         beat_last[$];
    int           beat_cyc[$];
    logic [7:0]   got_bytes[$];
    int           perm_cnt = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    logic         sv_pending = 1'b0;
    logic         hold_pending = 1'b0;
    logic [255:0] hold_data = '0;
    logic [33:0]  hold_ctl = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            sv_pending   <= 1'b0;
            hold_pending <= 1'b0;
        end else begin
            logic [255:0] kmask;
            kmask = '0;
            if (sv_pending)
                check("tvalid_after_state", 256'(m_tvalid), 256'(1));
            sv_pending <= state_valid_i && state_ready_o;
            if (hold_pending) begin
                check("hold_data", m_tdata, hold_data);
                check("hold_ctl", 256'({m_tvalid, m_tlast, m_tkeep}), 256'(hold_ctl));
            end
            hold_pending <= m_tvalid && !m_tready;
            hold_data    <= m_tdata;
            hold_ctl     <= {m_tvalid, m_tlast, m_tkeep};
            if (perm_req_o) begin
                perm_cnt <= perm_cnt + 1;
                check("ready_with_perm", 256'(state_ready_o), 256'(1));
            end
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                check("busy_at_done", 256'(busy_o), 256'(0));
            end
            if (m_tvalid && m_tready) begin
                for (int b = 0; b < 32; b++) begin
                    kmask[8*b +: 8] = {8{m_tkeep[b]}};
                    if (m_tkeep[b]) got_bytes.push_back(m_tdata[8*b +: 8]);
                end
                check("tdata_pad", m_tdata & ~kmask, 256'(0));
                beat_data.push_back(m_tdata);
                beat_keep.push_back(m_tkeep);
                beat_last.push_back(m_tlast);
                beat_cyc.push_back(cyc + 1);
            end
        end
    end

    function automatic logic [255:0] get_beat(input int i);
        if (i < 0 || i >= beat_data.size()) return 'x;
        return beat_data[i];
    endfunction

    function automatic int get_cyc(input int i);
        if (i < 0 || i >= beat_cyc.size()) return -1000;
        return beat_cyc[i];
    endfunction

    int req_beat_base;

    // One request: start, feed states whenever asked, collect beats, then check framing.
    // abort_beat >= 0 pulls rst_n while that beat index is being presented.
    task automatic run_req(input string name, input logic [1:0] mode, input int len,
                           input bit stall, input int abort_beat);
        int rate, exp_len, blk, done_base, perm_base, byte_base, start_cyc, n_beats, errs;
        logic [32:0] kw;
        rate      = rate_of(mode);
        exp_len   = (mode == 2'd0) ? 32 : (mode == 2'd1) ? 64 : len;
        blk       = 0;
        done_base = done_cnt;
        perm_base = perm_cnt;
        byte_base = got_bytes.size();
        req_beat_base = beat_data.size();

        start_i   = 1'b1;
        mode_i    = mode;
        out_len_i = 16'(len);
        @(posedge clk); #1;
        start_i   = 1'b0;
        start_cyc = cyc;

        for (int t = 0; t < 3000 && done_cnt == done_base; t++) begin
            if (abort_beat >= 0 && beat_data.size() - req_beat_base == abort_beat && m_tvalid) begin
                rst_n = 1'b0;
                #1;
                check({name, "_rst_tvalid"}, 256'(m_tvalid), 256'(0));
                check({name, "_rst_tdata"}, m_tdata, 256'(0));
                check({name, "_rst_ctl"}, 256'({m_tkeep, m_tlast, busy_o, done_o, perm_req_o, state_ready_o}), 256'(0));
                state_valid_i = 1'b0;
                m_tready = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check({name, "_no_done_after_abort"}, 256'(done_cnt - done_base), 256'(0));
                return;
            end
            if (state_ready_o) begin
                rate_data_i   = make_block(blk, rate);
                state_valid_i = 1'b1;
                blk++;
            end else begin
                state_valid_i = 1'b0;
            end
            m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        state_valid_i = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_tready = 1'b0;

        n_beats = (exp_len + 31) / 32;
        check({name, "_done_count"}, 256'(done_cnt - done_base), 256'(1));
        check({name, "_beats"}, 256'(beat_data.size() - req_beat_base), 256'(n_beats));
        check({name, "_bytes"}, 256'(got_bytes.size() - byte_base), 256'(exp_len));
        errs = 0;
        for (int j = 0; j < exp_len && byte_base + j < got_bytes.size(); j++)
            if (got_bytes[byte_base + j] !== exp_byte(j, rate)) errs++;
        check({name, "_stream_errors"}, 256'(errs), 256'(0));
        check({name, "_perm_count"}, 256'(perm_cnt - perm_base),
              256'((exp_len == 0) ? 0 : (exp_len + rate - 1) / rate - 1));
        for (int i = 0; i < n_beats && req_beat_base + i < beat_data.size(); i++) begin
            int rem;
            rem = exp_len - 32 * i;
            kw  = (rem >= 32) ? 33'h0FFFF_FFFF : (33'd1 << rem) - 33'd1;
            check($sformatf("%s_keep_last%0d", name, i),
                  256'({beat_keep[req_beat_base + i], beat_last[req_beat_base + i]}),
                  256'({kw[31:0], (i == n_beats - 1) ? 1'b1 : 1'b0}));
        end
        if (exp_len == 0)
            check({name, "_zero_done_latency"}, 256'(done_cyc), 256'(start_cyc));
        else
            check({name, "_done_latency"}, 256'(done_cyc), 256'(get_cyc(beat_data.size() - 1)));
        check({name, "_busy_after"}, 256'(busy_o), 256'(0));
    endtask

    initial begin
        logic [255:0] exp_v;

        #2 rst_n = 1'b0;
        #1;
        check("reset_tvalid", 256'(m_tvalid), 256'(0));
        check("reset_tdata", m_tdata, 256'(0));
        check("reset_ctl", 256'({m_tkeep, m_tlast, busy_o, done_o, perm_req_o, state_ready_o}), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // SHA3-256: one beat of state bytes 0..31
        run_req("sha3_256", 2'd0, 0, 1'b0, -1);
        exp_v = '0;
        for (int i = 0; i < 32; i++) exp_v[8*i +: 8] = 8'(i);
        check("sha3_256_beat0", get_beat(req_beat_base), exp_v);

        // SHA3-512: out_len is ignored; two back-to-back beats
        run_req("sha3_512", 2'd1, 5, 1'b0, -1);
        exp_v = '0;
        for (int i = 0; i < 32; i++) exp_v[8*i +: 8] = 8'(32 + i);
        check("sha3_512_beat1", get_beat(req_beat_base + 1), exp_v);
        check("sha3_512_back_to_back", 256'(get_cyc(req_beat_base + 1) - get_cyc(req_beat_base)), 256'(1));

        // SHAKE128 200 bytes: carry-bridged beat 5 and short beat 6
        run_req("shake128_200", 2'd2, 200, 1'b0, -1);
        exp_v = '0;
        for (int i = 0; i < 8; i++)  exp_v[8*i +: 8] = 8'(160 + i);
        for (int i = 8; i < 32; i++) exp_v[8*i +: 8] = 8'((i - 8) + 37);
        check("shake128_beat5", get_beat(req_beat_base + 5), exp_v);
        exp_v = '0;
        for (int i = 0; i < 8; i++) exp_v[8*i +: 8] = 8'(24 + i + 37);
        check("shake128_beat6", get_beat(req_beat_base + 6), exp_v);
        check("shake128_first5_rate", 256'(get_cyc(req_beat_base + 4) - get_cyc(req_beat_base)), 256'(4));

        // SHAKE256 300 bytes under random back-pressure: two permutations
        run_req("shake256_300", 2'd3, 300, 1'b1, -1);

        // SHAKE128 zero length: no beats, done right after start
        run_req("shake128_0", 2'd2, 0, 1'b0, -1);

        // Reset while beat 2 is on the bus, then a clean SHA3-256
        run_req("abort", 2'd2, 200, 1'b0, 2);
        run_req("post_abort", 2'd0, 0, 1'b0, -1);
        exp_v = '0;
        for (int i = 0; i < 32; i++) exp_v[8*i +: 8] = 8'(i);
        check("post_abort_beat0", get_beat(req_beat_base), exp_v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
